// File: rtl/uart_pkg.sv
// uart_pkg: types and constants shared by the UART transmit and receive paths.
//   uart_tx_state_t : transmit serializer state encoding
//   MIN_BAUD_DIV    : smallest usable baud divisor; smaller values are clamped up to it
package uart_pkg;

  localparam int MIN_BAUD_DIV = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LATCH,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_tx_state_t;

endpackage

// File: rtl/uart_tx_serializer_if.sv
// uart_tx_serializer_if: registered read port of the TX FIFO.
//   fifo_empty : FIFO empty flag            (FIFO -> serializer)
//   fifo_rd_en : read strobe, one per byte  (serializer -> FIFO)
//   fifo_data  : read data, valid the cycle after fifo_rd_en (FIFO -> serializer)
interface uart_tx_serializer_if #(
  parameter int DATA_WIDTH = 8
) ();

  logic                  fifo_empty;
  logic                  fifo_rd_en;
  logic [DATA_WIDTH-1:0] fifo_data;

  modport master (
    input  fifo_empty,
    input  fifo_data,
    output fifo_rd_en
  );

  modport slave (
    output fifo_empty,
    output fifo_data,
    input  fifo_rd_en
  );

endinterface

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: loadable down-counter that strikes once per bit period.
//   clk, resetn : core clock, synchronous active-low reset
//   load_i      : force a reload (held high while no bit is on the line)
//   reload_i    : reload value, i.e. bit period minus one
//   strike_o    : high in the last cycle of each bit period
module uart_baud_tick #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 load_i,
  input  logic [DIV_WIDTH-1:0] reload_i,
  output logic                 strike_o
);

  localparam logic [DIV_WIDTH-1:0] CNT_ONE = DIV_WIDTH'(1);

  logic [DIV_WIDTH-1:0] cnt_q;
  logic [DIV_WIDTH-1:0] cnt_d;

  assign strike_o = (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q - CNT_ONE;
    if (load_i || strike_o) begin
      cnt_d = reload_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: pops bytes from the TX FIFO and sends each as an async frame
// (start, LSB-first data, optional parity, 1 or 2 stop bits) on txd_o.
//   clk, resetn   : core clock, synchronous active-low reset
//   fifo          : TX FIFO read port (master side)
//   tx_en_i       : transmitter enable
//   baud_div_i    : cycles per bit, 0 and 1 act as 2
//   parity_en_i   : append parity bit;  parity_odd_i : 1 odd, 0 even
//   stop2_i       : two stop bits when high
//   txd_o         : registered serial output, idles high
//   busy_o        : high outside IDLE
//   tx_done_o     : one-cycle pulse in the final cycle of the last stop bit
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | line high, waiting for tx_en and a non-empty FIFO
// FETCH   | fifo_rd_en high for one cycle
// LATCH   | fifo_data valid; byte and frame config captured
// START   | start bit (0)
// DATA    | data bits, LSB first
// PARITY  | parity bit from the accumulator
// STOP    | one or two stop bits (1); FIFO re-sampled on exit
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  uart_tx_serializer_if.master  fifo,
  input  logic                  tx_en_i,
  input  logic [DIV_WIDTH-1:0]  baud_div_i,
  input  logic                  parity_en_i,
  input  logic                  parity_odd_i,
  input  logic                  stop2_i,
  output logic                  txd_o,
  output logic                  busy_o,
  output logic                  tx_done_o
);

  localparam int                   BCW      = $clog2(DATA_WIDTH);
  localparam logic [DIV_WIDTH-1:0] MIN_DIV  = DIV_WIDTH'(MIN_BAUD_DIV);
  localparam logic [DIV_WIDTH-1:0] DIV_ONE  = DIV_WIDTH'(1);
  localparam logic [BCW-1:0]       BIT_LAST = BCW'(DATA_WIDTH - 1);
  localparam logic [BCW-1:0]       BIT_ONE  = BCW'(1);

  uart_tx_state_t        state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DIV_WIDTH-1:0]  div_q, div_d;
  logic                  par_en_q, par_en_d;
  logic                  stop2_q, stop2_d;
  logic                  acc_q, acc_d;
  logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
  logic                  stop_cnt_q, stop_cnt_d;
  logic                  txd_q, txd_d;

  logic                  rd_en;
  logic                  tx_done;
  logic                  in_bit;
  logic                  strike;
  logic [DIV_WIDTH-1:0]  div_clamped;
  logic [DIV_WIDTH-1:0]  reload;

  assign div_clamped = (baud_div_i < MIN_DIV) ? MIN_DIV : baud_div_i;
  assign in_bit      = (state_q == ST_START) || (state_q == ST_DATA) ||
                       (state_q == ST_PARITY) || (state_q == ST_STOP);
  // Before START the counter is preloaded from the live input so the first
  // bit already runs at the divisor being latched this frame.
  assign reload      = in_bit ? (div_q - DIV_ONE) : (div_clamped - DIV_ONE);

  uart_baud_tick #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_baud_tick (
    .clk      (clk),
    .resetn   (resetn),
    .load_i   (!in_bit),
    .reload_i (reload),
    .strike_o (strike)
  );

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    div_d      = div_q;
    par_en_d   = par_en_q;
    stop2_d    = stop2_q;
    acc_d      = acc_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    rd_en      = 1'b0;
    tx_done    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (tx_en_i && !fifo.fifo_empty) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        rd_en   = 1'b1;
        state_d = ST_LATCH;
      end
      ST_LATCH: begin
        shift_d    = fifo.fifo_data;
        div_d      = div_clamped;
        par_en_d   = parity_en_i;
        stop2_d    = stop2_i;
        acc_d      = parity_odd_i;
        bit_cnt_d  = '0;
        stop_cnt_d = 1'b0;
        state_d    = ST_START;
      end
      ST_START: begin
        if (strike) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (strike) begin
          acc_d   = acc_q ^ shift_q[0];
          shift_d = shift_q >> 1;
          if (bit_cnt_q == BIT_LAST) begin
            bit_cnt_d = '0;
            state_d   = par_en_q ? ST_PARITY : ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_ONE;
          end
        end
      end
      ST_PARITY: begin
        if (strike) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (strike) begin
          if (stop2_q && !stop_cnt_q) begin
            stop_cnt_d = 1'b1;
          end else begin
            tx_done = 1'b1;
            state_d = (tx_en_i && !fifo.fifo_empty) ? ST_FETCH : ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // txd is registered, so it is derived from where the FSM is heading.
    unique case (state_d)
      ST_START:  txd_d = 1'b0;
      ST_DATA:   txd_d = shift_d[0];
      ST_PARITY: txd_d = acc_d;
      default:   txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      div_q      <= '0;
      par_en_q   <= 1'b0;
      stop2_q    <= 1'b0;
      acc_q      <= 1'b0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      txd_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      div_q      <= div_d;
      par_en_q   <= par_en_d;
      stop2_q    <= stop2_d;
      acc_q      <= acc_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      txd_q      <= txd_d;
    end
  end

  assign fifo.fifo_rd_en = rd_en;
  assign txd_o           = txd_q;
  assign busy_o          = (state_q != ST_IDLE);
  assign tx_done_o       = tx_done;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer: randomized and directed frames checked against a
// bit-list model of an async frame; a small FIFO model feeds the DUT.
module tb_uart_tx_serializer;

  localparam int DW   = 8;
  localparam int DIVW = 16;

  logic            clk    = 1'b0;
  logic            resetn = 1'b0;
  logic            tx_en;
  logic [DIVW-1:0] baud_div;
  logic            parity_en;
  logic            parity_odd;
  logic            stop2;
  logic            txd;
  logic            busy;
  logic            tx_done;

  uart_tx_serializer_if #(.DATA_WIDTH(DW)) fifo_bus ();

  uart_tx_serializer #(
    .DATA_WIDTH (DW),
    .DIV_WIDTH  (DIVW)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .fifo         (fifo_bus),
    .tx_en_i      (tx_en),
    .baud_div_i   (baud_div),
    .parity_en_i  (parity_en),
    .parity_odd_i (parity_odd),
    .stop2_i      (stop2),
    .txd_o        (txd),
    .busy_o       (busy),
    .tx_done_o    (tx_done)
  );

  always #5 clk = ~clk;

  // FIFO model: push side owned by the stimulus, pop side by the read port.
  logic [DW-1:0] fmem [0:255];
  int push_cnt = 0;
  int pop_cnt  = 0;

  assign fifo_bus.fifo_empty = (push_cnt == pop_cnt);

  always @(posedge clk) begin
    if (fifo_bus.fifo_rd_en && (push_cnt != pop_cnt)) begin
      fifo_bus.fifo_data <= fmem[pop_cnt];
      pop_cnt            <= pop_cnt + 1;
    end
  end

  // Monitor
  int cyc         = 0;
  int rd_cnt      = 0;
  int last_rd_cyc = 0;
  int viol        = 0;
  int done_cnt    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (fifo_bus.fifo_rd_en) begin
      rd_cnt      <= rd_cnt + 1;
      last_rd_cyc <= cyc;
      if (fifo_bus.fifo_empty) viol <= viol + 1;
    end
    if (tx_done) done_cnt <= done_cnt + 1;
  end

  int checks     = 0;
  int failures   = 0;
  int frames_run = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [DW-1:0] b);
    #1;
    fmem[push_cnt] = b;
    push_cnt++;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Waits for the start bit, then checks every cycle of the frame against the
  // bit list. mid_act at cycle mid_k: 1 drops tx_en, 2 scrambles the config.
  task automatic run_frame(input logic [DW-1:0] data, input int div, input bit pe,
                           input bit po, input bit s2, input int mid_k,
                           input int mid_act, output int gap);
    bit eb [12];
    int nb, ediv, total, errs, derr;
    bit started;
    ediv = (div < 2) ? 2 : div;
    nb = 0;
    eb[nb++] = 1'b0;
    for (int i = 0; i < DW; i++) eb[nb++] = data[i];
    if (pe) eb[nb++] = po ? ~(^data) : (^data);
    eb[nb++] = 1'b1;
    if (s2) eb[nb++] = 1'b1;
    total = nb * ediv;

    gap = 0;
    started = 1'b0;
    for (int w = 0; w < 400 && !started; w++) begin
      @(negedge clk);
      if (txd === 1'b0) started = 1'b1;
      else gap++;
    end
    chk("frame_start", 32'(started), 1);
    if (!started) return;
    chk("start_latency", cyc - last_rd_cyc, 2);

    errs = 0;
    derr = 0;
    for (int k = 0; k < total; k++) begin
      if (k > 0) @(negedge clk);
      if (txd !== eb[k / ediv]) errs++;
      if (tx_done !== (k == total - 1)) derr++;
      if (k == mid_k) begin
        if (mid_act == 1) tx_en = 1'b0;
        if (mid_act == 2) begin
          baud_div   = DIVW'($urandom_range(3, 9));
          parity_en  = ~parity_en;
          parity_odd = ~parity_odd;
          stop2      = ~stop2;
        end
      end
    end
    chk("frame_txd", errs, 0);
    chk("frame_done", derr, 0);
    frames_run++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] b [3];
    int gap, rd0;
    bit seen;

    tx_en      = 1'b0;
    baud_div   = 16'd4;
    parity_en  = 1'b0;
    parity_odd = 1'b0;
    stop2      = 1'b0;
    resetn     = 1'b0;
    idle(3);
    chk("rst_txd", 32'(txd), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_rd_en", 32'(fifo_bus.fifo_rd_en), 0);
    chk("rst_tx_done", 32'(tx_done), 0);
    resetn = 1'b1;
    idle(2);

    // 0x55, 8N1, divisor 4
    tx_en = 1'b1;
    rd0 = rd_cnt;
    push(8'h55);
    run_frame(8'h55, 4, 0, 0, 0, -1, 0, gap);
    idle(10);
    chk("t55_rd_pulses", rd_cnt - rd0, 1);
    chk("t55_busy_after", 32'(busy), 0);
    chk("t55_txd_after", 32'(txd), 1);

    // 0xA3 with even then odd parity
    parity_en = 1'b1;
    parity_odd = 1'b0;
    push(8'hA3);
    run_frame(8'hA3, 4, 1, 0, 0, -1, 0, gap);
    idle(3);
    parity_odd = 1'b1;
    push(8'hA3);
    run_frame(8'hA3, 4, 1, 1, 0, -1, 0, gap);
    idle(3);

    // three queued bytes, two stop bits, divisor 8
    parity_en = 1'b0;
    stop2 = 1'b1;
    baud_div = 16'd8;
    rd0 = rd_cnt;
    for (int i = 0; i < 3; i++) begin
      b[i] = DW'($urandom);
      push(b[i]);
    end
    for (int i = 0; i < 3; i++) begin
      run_frame(b[i], 8, 0, 0, 1, -1, 0, gap);
      if (i > 0) chk("b2b_gap", gap, 2);
    end
    idle(20);
    chk("b2b_rd_pulses", rd_cnt - rd0, 3);
    chk("b2b_fifo_empty", 32'(fifo_bus.fifo_empty), 1);
    chk("b2b_busy_after", 32'(busy), 0);

    // divisor 0 and 1 clamp to 2
    stop2 = 1'b0;
    baud_div = 16'd0;
    push(8'hC6);
    run_frame(8'hC6, 0, 0, 0, 0, -1, 0, gap);
    idle(3);
    baud_div = 16'd1;
    push(8'h39);
    run_frame(8'h39, 1, 0, 0, 0, -1, 0, gap);
    idle(3);

    // tx_en dropped mid-DATA with bytes still queued
    baud_div = 16'd3;
    for (int i = 0; i < 3; i++) b[i] = DW'($urandom);
    rd0 = rd_cnt;
    for (int i = 0; i < 3; i++) push(b[i]);
    run_frame(b[0], 3, 0, 0, 0, 15, 1, gap);
    idle(40);
    chk("txen_rd_pulses", rd_cnt - rd0, 1);
    chk("txen_busy_after", 32'(busy), 0);
    chk("txen_txd_after", 32'(txd), 1);
    tx_en = 1'b1;
    run_frame(b[1], 3, 0, 0, 0, -1, 0, gap);
    run_frame(b[2], 3, 0, 0, 0, -1, 0, gap);
    chk("txen_resume_gap", gap, 2);
    idle(5);

    // config changes mid-frame are ignored until the next byte
    baud_div = 16'd5;
    parity_en = 1'b1;
    parity_odd = 1'b0;
    stop2 = 1'b0;
    push(8'h5A);
    run_frame(8'h5A, 5, 1, 0, 0, 20, 2, gap);
    idle(5);

    // reset mid-DATA
    baud_div = 16'd4;
    parity_en = 1'b0;
    parity_odd = 1'b0;
    stop2 = 1'b0;
    b[0] = DW'($urandom);
    b[1] = DW'($urandom);
    push(b[0]);
    push(b[1]);
    seen = 1'b0;
    for (int w = 0; w < 50 && !seen; w++) begin
      @(negedge clk);
      if (txd === 1'b0) seen = 1'b1;
    end
    chk("rstmid_started", 32'(seen), 1);
    idle(10);
    rd0 = rd_cnt;
    resetn = 1'b0;
    idle(1);
    chk("rstmid_txd", 32'(txd), 1);
    chk("rstmid_busy", 32'(busy), 0);
    chk("rstmid_rd_en", 32'(fifo_bus.fifo_rd_en), 0);
    idle(3);
    chk("rstmid_no_rd", rd_cnt - rd0, 0);
    resetn = 1'b1;
    run_frame(b[1], 4, 0, 0, 0, -1, 0, gap);
    idle(5);
    chk("rstmid_rd_after", rd_cnt - rd0, 1);

    // randomized frames
    for (int n = 0; n < 12; n++) begin
      int d;
      logic [DW-1:0] v;
      d          = $urandom_range(0, 6);
      v          = DW'($urandom);
      baud_div   = DIVW'(d);
      parity_en  = 1'($urandom);
      parity_odd = 1'($urandom);
      stop2      = 1'($urandom);
      push(v);
      run_frame(v, d, parity_en, parity_odd, stop2, -1, 0, gap);
      idle($urandom_range(1, 4));
    end

    idle(20);
    chk("rd_while_empty", viol, 0);
    chk("tx_done_total", done_cnt, frames_run);
    chk("final_busy", 32'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
